// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register bank: frame FSM states,
// reserved addresses and command-byte field positions.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_MEM
  } state_e;

  localparam logic [6:0] MEM_ADDR      = 7'h7F;
  localparam logic [6:0] LAST_REG_ADDR = 7'h7E;
  localparam logic [3:0] STATUS_TAG    = 4'hA;
  localparam int         CMD_W         = 8;
  localparam int         CMD_WR_BIT    = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings SPI pins into the clk domain (two-flop sync plus edge register)
// and produces single-clk edge pulses for sck and ncs.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  input  logic ncs,
  output logic sck_rise,
  output logic sck_fall,
  output logic ncs_rise,
  output logic ncs_fall,
  output logic mosi_s
);

  logic [1:0] sck_sync_q, sck_sync_d;
  logic [1:0] ncs_sync_q, ncs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic       sck_edge_q, sck_edge_d;
  logic       ncs_edge_q, ncs_edge_d;

  always_comb begin
    sck_sync_d  = {sck_sync_q[0], sck};
    ncs_sync_d  = {ncs_sync_q[0], ncs};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    sck_edge_d  = sck_sync_q[1];
    ncs_edge_d  = ncs_sync_q[1];
  end

  // ncs resets to the deselected level so reset release never looks like a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= 2'b00;
      ncs_sync_q  <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_edge_q  <= 1'b0;
      ncs_edge_q  <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_edge_q  <= sck_edge_d;
      ncs_edge_q  <= ncs_edge_d;
    end
  end

  assign sck_rise = sck_sync_q[1] & ~sck_edge_q;
  assign sck_fall = ~sck_sync_q[1] & sck_edge_q;
  assign ncs_rise = ncs_sync_q[1] & ~ncs_edge_q;
  assign ncs_fall = ~ncs_sync_q[1] & ncs_edge_q;
  assign mosi_s   = mosi_sync_q[1];

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 slave exposing writable control registers, read-only status
// registers and a sequential memory read stream behind a command byte.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int          NUM_WR   = 4,
  parameter int          NUM_RD   = 4,
  parameter int          REG_W    = 32,
  parameter int          MEM_AW   = 12,
  parameter int          MEM_DW   = 16,
  parameter logic [31:0] WR_RESET = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sck,
  input  logic                    mosi,
  input  logic                    ncs,
  output logic                    miso,
  input  logic [NUM_RD*REG_W-1:0] rd_data,
  output logic [NUM_WR*REG_W-1:0] wr_data,
  output logic [NUM_WR-1:0]       wr_strobe,
  output logic [7:0]              cmd,
  output logic [MEM_AW-1:0]       mem_addr,
  input  logic [MEM_DW-1:0]       mem_data,
  output logic                    frame_active
);

  localparam int SH_W  = max_int(max_int(REG_W, MEM_DW), CMD_W);
  localparam int CNT_W = $clog2(SH_W + 1);

  logic sck_rise, sck_fall, ncs_rise, ncs_fall, mosi_s;

  spi_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .sck     (sck),
    .mosi    (mosi),
    .ncs     (ncs),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall),
    .ncs_rise(ncs_rise),
    .ncs_fall(ncs_fall),
    .mosi_s  (mosi_s)
  );

  state_e             state_q, state_d;
  logic [SH_W-1:0]    tx_q, tx_d;
  logic [SH_W-2:0]    rx_q, rx_d;
  logic [SH_W-1:0]    rx_shift;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d, word_len;
  logic [6:0]         addr_q, addr_d, addr_inc, next_addr;
  logic [7:0]         cmd_q, cmd_d;
  logic [REG_W-1:0]   regs_q [NUM_WR];
  logic [REG_W-1:0]   regs_d [NUM_WR];
  logic [NUM_WR-1:0]  strobe_q, strobe_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [1:0]         mem_pend_q, mem_pend_d;
  logic               ovf_q, ovf_d;
  logic [REG_W-1:0]   load_val;
  logic               word_done, wr_hit;

  always_comb begin
    case (state_q)
      ST_DATA: word_len = CNT_W'(REG_W);
      ST_MEM:  word_len = CNT_W'(MEM_DW);
      default: word_len = CNT_W'(CMD_W);
    endcase
    rx_shift  = {rx_q, mosi_s};
    word_done = sck_rise && (state_q != ST_IDLE) && (bit_cnt_q == word_len - 1'b1);
    addr_inc  = (addr_q == LAST_REG_ADDR) ? 7'h00 : addr_q + 7'd1;
    next_addr = (state_q == ST_CMD) ? rx_shift[6:0] : addr_inc;
  end

  // Word presented for the next address; rd_data is frozen into the shifter at load
  always_comb begin
    load_val = '0;
    for (int k = 0; k < NUM_WR; k++)
      if (next_addr == 7'(k)) load_val = regs_q[k];
    for (int k = 0; k < NUM_RD; k++)
      if (next_addr == 7'(NUM_WR + k)) load_val = rd_data[k*REG_W +: REG_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ncs_fall)
      state_d = ST_CMD;
    else if (ncs_rise)
      state_d = ST_IDLE;
    else if (state_q == ST_CMD && word_done)
      state_d = (rx_shift[6:0] == MEM_ADDR) ? ST_MEM : ST_DATA;
  end

  always_comb begin
    frame_active = (state_q != ST_IDLE);
    miso         = frame_active & tx_q[SH_W-1];
  end

  always_comb begin
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    regs_d     = regs_q;
    strobe_d   = '0;
    mem_addr_d = mem_addr_q;
    mem_pend_d = {mem_pend_q[0], 1'b0};
    ovf_d      = ovf_q;
    wr_hit     = 1'b0;
    if (ncs_fall) begin
      tx_d                  = '0;
      tx_d[SH_W-1 -: CMD_W] = {STATUS_TAG, 3'b000, ovf_q};
      bit_cnt_d             = '0;
      mem_pend_d            = '0;
    end else if (state_q != ST_IDLE) begin
      // The fall right after a load keeps the fresh MSB on miso
      if (sck_fall && bit_cnt_q != '0) tx_d = tx_q << 1;
      if (sck_rise) begin
        rx_d      = rx_shift[SH_W-2:0];
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (word_done) begin
        bit_cnt_d = '0;
        case (state_q)
          ST_CMD: begin
            cmd_d  = rx_shift[7:0];
            addr_d = rx_shift[6:0];
            ovf_d  = 1'b0;
            if (rx_shift[6:0] == MEM_ADDR) begin
              mem_addr_d    = '0;
              mem_pend_d[0] = 1'b1;
            end else begin
              tx_d                  = '0;
              tx_d[SH_W-1 -: REG_W] = load_val;
            end
          end
          ST_DATA: begin
            if (cmd_q[CMD_WR_BIT]) begin
              for (int k = 0; k < NUM_WR; k++)
                if (addr_q == 7'(k)) begin
                  regs_d[k]   = rx_shift[REG_W-1:0];
                  strobe_d[k] = 1'b1;
                  wr_hit      = 1'b1;
                end
              if (!wr_hit) ovf_d = 1'b1;
            end
            addr_d                = addr_inc;
            tx_d                  = '0;
            tx_d[SH_W-1 -: REG_W] = load_val;
          end
          ST_MEM: begin
            mem_addr_d    = mem_addr_q + 1'b1;
            mem_pend_d[0] = 1'b1;
          end
          default: ;
        endcase
      end
      // Memory answers one clk after mem_addr moves, so reload two clks after the request
      if (mem_pend_q[1]) begin
        tx_d                   = '0;
        tx_d[SH_W-1 -: MEM_DW] = mem_data;
      end
      if (ncs_rise) mem_pend_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q       <= '0;
      rx_q       <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      strobe_q   <= '0;
      mem_addr_q <= '0;
      mem_pend_q <= '0;
      ovf_q      <= 1'b0;
      for (int k = 0; k < NUM_WR; k++) regs_q[k] <= WR_RESET[REG_W-1:0];
    end else begin
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      strobe_q   <= strobe_d;
      mem_addr_q <= mem_addr_d;
      mem_pend_q <= mem_pend_d;
      ovf_q      <= ovf_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_out
    assign wr_data[g*REG_W +: REG_W] = regs_q[g];
  end

  assign wr_strobe = strobe_q;
  assign cmd       = cmd_q;
  assign mem_addr  = mem_addr_q;

endmodule
